cache_coherency_ctrl: RTL
=========================

// Module: cache_coherency_ctrl
// PURPOSE
// - Sequencing FSM for the 8-line direct-mapped ACE cache datapath: runs CPU read/write lookups,
//   dirty write-back, line fill, shared-line upgrade and snoop handling.
// - Drives the datapath strobes and the ACE channel valid/ready handshakes. Snoops take priority
//   over new CPU requests.
// PARAMETERS
// - WIDTH_STATE  3   line-state width; codes UC=000 UD=001 SC=010 SD=011 I=100
// - CNT_W        16  width of performance counters (used only with CACHE_PERF_CNT_EN)
// PORTS
// - clk  in 1  clock
// - rst_n  in 1  asynchronous active-low reset
// - cpu_req / cpu_we  in 1/1  request, held high until cpu_done; cpu_we=1 for write; cpu addr/data stable
// - cpu_done / cpu_err  out 1/1  one-cycle completion pulse; cpu_err marks a bus error
// - cache_hit  in 1  datapath tag+valid match for the cpu address
// - line_state  in WIDTH_STATE  state of the indexed line
// - write_from_cpu / write_from_interconnect  out 1/1  datapath write strobes
// - mux_en / new_state  out 1/WIDTH_STATE  forced state update of the indexed line
// - read_shared / make_unique / write_clean  out 1 each  ACE transaction-type selects
// - read_resp_en / ac_enable  out 1/1  enable RRESP-driven / snoop-driven state update
// - ar_valid,ar_ready / aw_valid,aw_ready / w_valid,w_ready  out,in  address and write-data handshakes
// - r_valid,r_last,r_okay / b_valid,b_okay  in  read-data and write-response beats (single beat, LEN=0)
// - ac_valid / ac_ready  in/out  snoop address handshake
// - snp_cr_resp / snp_data  in 5/1  datapath CR_RESP and response_data
// - cr_valid,cr_ready / cd_valid,cd_ready  out,in  snoop response and snoop data handshakes
// - cr_resp / cd_last  out 5/1  registered snoop response; cd_last = cd_valid
// - hit_cnt / miss_cnt / wb_cnt  out CNT_W each  performance counters (CACHE_PERF_CNT_EN only)
// BEHAVIOUR
// - Reset: FSM=IDLE; every output 0; new_state=100. Reset mid-transaction aborts it, and no
//   cpu_done is issued.
// - Strobes are combinational (Moore) from the state. valid outputs hold until their matching
//   ready is seen high at a clock edge.
// - IDLE: ac_valid -> SNP_UPD. Otherwise cpu_req -> LOOKUP, latching cpu_we.
//   Both valid in the same cycle: snoop wins, CPU waits.
// - LOOKUP (1 cycle), taking the first matching case:
//   - hit & read -> DONE.
//   - hit & write & state in {UC,UD} -> CPU_WR.
//   - hit & write & state in {SC,SD} -> UPG_AR.
//   - miss & state in {UD,SD} -> WB.
//   - other miss -> RD_AR.
// - WB: write_clean=1; aw_valid and w_valid raised together and dropped independently on their
//   readies. Both accepted -> WB_B.
//   WB_B: on b_valid, b_okay=1 -> RD_AR; b_okay=0 -> ERR.
// - RD_AR: read_shared=1, ar_valid until ar_ready -> RD_R.
//   RD_R: read_resp_en=1; on r_valid&r_last:
//   - r_okay=1: write_from_interconnect=1 in that cycle (state taken from RRESP), then -> LOOKUP.
//     A write miss therefore completes through the write-hit path.
//   - r_okay=0: no write -> ERR.
// - UPG_AR: make_unique=1, ar_valid until ar_ready -> UPG_R.
//   UPG_R: on r_valid&r_last, r_okay -> CPU_WR, else -> ERR. Data is never written here.
// - CPU_WR: write_from_cpu=1 for 1 cycle -> SET_UD.
//   SET_UD: mux_en=1, new_state=001 for 1 cycle -> DONE.
// - DONE: cpu_done=1 -> IDLE. ERR: cpu_done=1, cpu_err=1, line untouched -> IDLE.
// - Latency, no bus stalls: read hit 3 cycles req->done; write hit UC/UD 5 cycles.
// - SNP_UPD (1 cycle): ac_ready=1 and ac_enable=1 (datapath commits the snoop state);
//   captures cr_resp<=snp_cr_resp and need_data<=snp_data&snp_cr_resp[0] -> SNP_CR.
// - SNP_CR: cr_valid until cr_ready -> SNP_CD if need_data, else IDLE.
//   SNP_CD: cd_valid=cd_last=1 until cd_ready -> IDLE.
// - Snoops are accepted only in IDLE. The interconnect must not stall R/B on this master's
//   snoop completion.
// - A cpu_req drop before cpu_done is illegal; a bench assertion flags it.
// CONFIGURATION
// - CACHE_PERF_CNT_EN defined:
//   - hit_cnt increments on LOOKUP&hit when entered from IDLE.
//   - miss_cnt increments on LOOKUP&miss; wb_cnt increments on WB_B&b_valid&b_okay.
//   - All counters saturate at all-ones and reset to 0.
// - CACHE_PERF_CNT_EN undefined: counter ports tied to 0, no counter flops.
// STRUCTURE
// - cache_pkg:
//   - line_state_e (UC,UD,SC,SD,I); ctrl_state_e FSM enum.
//   - CR_RESP bit-position constants; ST_W=3.
// - Sub-module cache_perf_cnt: saturating counter bank, instantiated under CACHE_PERF_CNT_EN.
// TESTING
// - Read hit on UC line, ac_valid=0: cpu_done 3 cycles after cpu_req; no bus valid ever high.
// - Write miss, victim UD: aw/w with write_clean=1, b_okay.
//   - Then ar with read_shared, RRESP->UC, write_from_cpu, then new_state=001; done, cpu_err=0.
// - Write hit on SC: make_unique ar, r_okay -> CPU_WR -> SET_UD; final line_state=001.
// - ac_valid and cpu_req same cycle in IDLE: SNP_UPD first.
//   - snp_cr_resp=00101, snp_data=1: cr_resp=00101, cd_valid until cd_ready.
//   - Then LOOKUP runs.
// - RD_R with r_okay=0: no write_from_interconnect; cpu_done=cpu_err=1.
//   - rst_n pulsed in WB_B -> IDLE, all outputs 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the ACE cache sequencing controller.
package cache_pkg;

  localparam int unsigned ST_W = 3;
  localparam int unsigned CS_W = 4;

  typedef enum logic [ST_W-1:0] {
    LS_UC = 3'b000,
    LS_UD = 3'b001,
    LS_SC = 3'b010,
    LS_SD = 3'b011,
    LS_I  = 3'b100
  } line_state_e;

  typedef enum logic [CS_W-1:0] {
    CS_IDLE, CS_LOOKUP, CS_WB, CS_WB_B, CS_RD_AR, CS_RD_R, CS_UPG_AR, CS_UPG_R,
    CS_CPU_WR, CS_SET_UD, CS_DONE, CS_ERR, CS_SNP_UPD, CS_SNP_CR, CS_SNP_CD
  } ctrl_state_e;

  // ACE CRRESP bit positions
  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

endpackage

// File: rtl/cache_coherency_ctrl_perf_cnt.sv
// Saturating hit/miss/write-back counter bank.
module cache_perf_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_inc,
  input  logic             miss_inc,
  input  logic             wb_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_inc && (hit_cnt != {CNT_W{1'b1}}))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_inc && (miss_cnt != {CNT_W{1'b1}}))
        miss_cnt <= miss_cnt + CNT_W'(1);
      if (wb_inc && (wb_cnt != {CNT_W{1'b1}}))
        wb_cnt <= wb_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_coherency_ctrl.sv
// Sequencing FSM for the 8-line direct-mapped ACE cache datapath.
// Optional performance counters enabled by defining CACHE_PERF_CNT_EN.
module cache_coherency_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH_STATE = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  output logic                   cpu_done,
  output logic                   cpu_err,
  input  logic                   cache_hit,
  input  logic [WIDTH_STATE-1:0] line_state,
  output logic                   write_from_cpu,
  output logic                   write_from_interconnect,
  output logic                   mux_en,
  output logic [WIDTH_STATE-1:0] new_state,
  output logic                   read_shared,
  output logic                   make_unique,
  output logic                   write_clean,
  output logic                   read_resp_en,
  output logic                   ac_enable,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic                   w_valid,
  input  logic                   w_ready,
  input  logic                   r_valid,
  input  logic                   r_last,
  input  logic                   r_okay,
  input  logic                   b_valid,
  input  logic                   b_okay,
  input  logic                   ac_valid,
  output logic                   ac_ready,
  input  logic [4:0]             snp_cr_resp,
  input  logic                   snp_data,
  output logic                   cr_valid,
  input  logic                   cr_ready,
  output logic                   cd_valid,
  input  logic                   cd_ready,
  output logic [4:0]             cr_resp,
  output logic                   cd_last,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [CNT_W-1:0]       wb_cnt
);

  localparam logic [3:0] S_IDLE    = CS_IDLE;
  localparam logic [3:0] S_LOOKUP  = CS_LOOKUP;
  localparam logic [3:0] S_WB      = CS_WB;
  localparam logic [3:0] S_WB_B    = CS_WB_B;
  localparam logic [3:0] S_RD_AR   = CS_RD_AR;
  localparam logic [3:0] S_RD_R    = CS_RD_R;
  localparam logic [3:0] S_UPG_AR  = CS_UPG_AR;
  localparam logic [3:0] S_UPG_R   = CS_UPG_R;
  localparam logic [3:0] S_CPU_WR  = CS_CPU_WR;
  localparam logic [3:0] S_SET_UD  = CS_SET_UD;
  localparam logic [3:0] S_DONE    = CS_DONE;
  localparam logic [3:0] S_ERR     = CS_ERR;
  localparam logic [3:0] S_SNP_UPD = CS_SNP_UPD;
  localparam logic [3:0] S_SNP_CR  = CS_SNP_CR;
  localparam logic [3:0] S_SNP_CD  = CS_SNP_CD;

  logic [3:0] state_q, state_d;
  logic       we_q, aw_done_q, w_done_q, need_data_q;
  logic [4:0] cr_resp_q;
  logic       line_unique, line_dirty;

  assign line_unique = (line_state == WIDTH_STATE'(LS_UC)) || (line_state == WIDTH_STATE'(LS_UD));
  assign line_dirty  = (line_state == WIDTH_STATE'(LS_UD)) || (line_state == WIDTH_STATE'(LS_SD));
  assign cr_resp     = cr_resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      need_data_q <= 1'b0;
      cr_resp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_req)
        we_q <= cpu_we;
      // AW and W complete independently; remember which one is already accepted
      if (state_q == S_WB) begin
        if (aw_ready) aw_done_q <= 1'b1;
        if (w_ready)  w_done_q  <= 1'b1;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == S_SNP_UPD) begin
        cr_resp_q   <= snp_cr_resp;
        need_data_q <= snp_data & snp_cr_resp[CR_DATA_TRANSFER];
      end
    end
  end

  always_comb begin
    state_d                 = state_q;
    cpu_done                = 1'b0;
    cpu_err                 = 1'b0;
    write_from_cpu          = 1'b0;
    write_from_interconnect = 1'b0;
    mux_en                  = 1'b0;
    new_state               = WIDTH_STATE'(LS_I);
    read_shared             = 1'b0;
    make_unique             = 1'b0;
    write_clean             = 1'b0;
    read_resp_en            = 1'b0;
    ac_enable               = 1'b0;
    ar_valid                = 1'b0;
    aw_valid                = 1'b0;
    w_valid                 = 1'b0;
    ac_ready                = 1'b0;
    cr_valid                = 1'b0;
    cd_valid                = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ac_valid)     state_d = S_SNP_UPD;
        else if (cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cache_hit && !we_q)     state_d = S_DONE;
        else if (cache_hit)         state_d = line_unique ? S_CPU_WR : S_UPG_AR;
        else if (line_dirty)        state_d = S_WB;
        else                        state_d = S_RD_AR;
      end
      S_WB: begin
        write_clean = 1'b1;
        aw_valid    = !aw_done_q;
        w_valid     = !w_done_q;
        if ((aw_done_q || aw_ready) && (w_done_q || w_ready)) state_d = S_WB_B;
      end
      S_WB_B: begin
        if (b_valid) state_d = b_okay ? S_RD_AR : S_ERR;
      end
      S_RD_AR: begin
        read_shared = 1'b1;
        ar_valid    = 1'b1;
        if (ar_ready) state_d = S_RD_R;
      end
      S_RD_R: begin
        read_resp_en = 1'b1;
        // Fill commits in the beat cycle; write misses then re-run the lookup as a hit
        if (r_valid && r_last) begin
          if (r_okay) begin
            write_from_interconnect = 1'b1;
            state_d                 = S_LOOKUP;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_UPG_AR: begin
        make_unique = 1'b1;
        ar_valid    = 1'b1;
        if (ar_ready) state_d = S_UPG_R;
      end
      S_UPG_R: begin
        if (r_valid && r_last) state_d = r_okay ? S_CPU_WR : S_ERR;
      end
      S_CPU_WR: begin
        write_from_cpu = 1'b1;
        state_d        = S_SET_UD;
      end
      S_SET_UD: begin
        mux_en    = 1'b1;
        new_state = WIDTH_STATE'(LS_UD);
        state_d   = S_DONE;
      end
      S_DONE: begin
        cpu_done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        cpu_done = 1'b1;
        cpu_err  = 1'b1;
        state_d  = S_IDLE;
      end
      S_SNP_UPD: begin
        ac_ready  = 1'b1;
        ac_enable = 1'b1;
        state_d   = S_SNP_CR;
      end
      S_SNP_CR: begin
        cr_valid = 1'b1;
        if (cr_ready) state_d = need_data_q ? S_SNP_CD : S_IDLE;
      end
      S_SNP_CD: begin
        cd_valid = 1'b1;
        if (cd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cd_last = cd_valid;
  end

`ifdef CACHE_PERF_CNT_EN
  logic from_idle_q;

  // Hits are counted only for the first lookup of a request, not the post-fill re-lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) from_idle_q <= 1'b0;
    else        from_idle_q <= (state_q == S_IDLE);
  end

  cache_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_inc  ((state_q == S_LOOKUP) && cache_hit && from_idle_q),
    .miss_inc ((state_q == S_LOOKUP) && !cache_hit),
    .wb_inc   ((state_q == S_WB_B) && b_valid && b_okay),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule
